// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter and next-PC generator
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INSN_BYTES   = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            trap_ret,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc_out,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK =
        (ALIGN_BITS == 0) ? '0 : XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_fetch_valid;
    logic            r_misaligned;

    logic            w_redirect;
    logic            w_soft_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_target_bad;

    assign w_soft_redirect = trap_ret | jump | branch_taken;
    assign w_redirect      = trap | w_soft_redirect;

    always_comb begin
        w_target = branch_target;
        if (trap_ret) begin
            w_target = r_epc;
        end else if (jump) begin
            w_target = jump_target;
        end
        w_target_bad = |(w_target & ALIGN_MASK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_epc         <= '0;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (trap) begin
                        r_pc  <= TRAP_VECTOR;
                        r_epc <= r_pc;
                    end else if (w_soft_redirect && w_target_bad) begin
                        // A bad target faults at the instruction that requested it
                        r_pc         <= TRAP_VECTOR;
                        r_epc        <= r_pc;
                        r_misaligned <= 1'b1;
                    end else if (w_soft_redirect) begin
                        r_pc <= w_target;
                    end else if (!stall && fetch_ready) begin
                        r_pc <= pc_plus;
                    end
                    if (halt && !w_redirect) begin
                        r_state       <= HALTED;
                        r_fetch_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    if (trap) begin
                        r_pc          <= TRAP_VECTOR;
                        r_epc         <= r_pc;
                        r_state       <= RUN;
                        r_fetch_valid <= 1'b1;
                    end else if (resume) begin
                        r_state       <= RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign pc_plus     = r_pc + XLEN'(INSN_BYTES);
    assign epc_out     = r_epc;
    assign fetch_valid = r_fetch_valid;
    assign misaligned  = r_misaligned;

endmodule
